// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 8-bit pipelined processor.
// Owns the PC, the fetched-instruction register, the two-byte immediate capture and interrupt latching.
module fetch_stage #(
  parameter int                PC_W      = 8,
  parameter logic [PC_W-1:0]   RESET_VEC = 8'h00,
  parameter logic [PC_W-1:0]   INT_VEC   = 8'h01
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] instr_addr,
  input  logic [7:0]      instr_data,
  input  logic            PC_Write_En,
  input  logic            IF_ID_Write_En,
  input  logic            Inject_Int,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            INTR,
  output logic            int_req,
  output logic [PC_W-1:0] int_ret_pc,
  output logic [3:0]      opcode,
  output logic [1:0]      ra,
  output logic [1:0]      rb,
  output logic [PC_W-1:0] if_id_pc1,
  output logic [7:0]      if_id_imm,
  output logic            if_id_valid
);

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] pc_next_s;
  logic [7:0]      instr_r;
  logic            valid_r;
  logic [PC_W-1:0] pc1_r;
  logic [7:0]      imm_r;
  logic            int_req_r;
  logic [PC_W-1:0] int_ret_pc_r;
  logic            flush_s;
  logic            int_accept_s;
  logic            imm_load_s;

  // Sequential increment wraps naturally at the PC width.
  assign pc_inc_s     = pc_r + PC_W'(1);
  assign flush_s      = branch_taken | Inject_Int;
  // A branch in the same cycle owns the PC, so the interrupt is not consumed.
  assign int_accept_s = Inject_Int & ~branch_taken;
  // Hold of IF/ID with the PC still moving means the second byte of a two-byte op is on the bus.
  assign imm_load_s   = ~IF_ID_Write_En & PC_Write_En & ~flush_s;

  // Next-PC selection: redirect, interrupt vector, hold, or sequential.
  always_comb begin
    pc_next_s = pc_inc_s;
    if (branch_taken) begin
      pc_next_s = branch_target;
    end else if (Inject_Int) begin
      pc_next_s = INT_VEC;
    end else if (!PC_Write_En) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_VEC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID instruction, valid flag and return-address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r <= 8'h00;
      valid_r <= 1'b0;
      pc1_r   <= {PC_W{1'b0}};
    end else if (flush_s) begin
      instr_r <= 8'h00;
      valid_r <= 1'b0;
    end else if (IF_ID_Write_En) begin
      instr_r <= instr_data;
      valid_r <= 1'b1;
      pc1_r   <= pc_inc_s;
    end else begin
      instr_r <= instr_r;
      valid_r <= valid_r;
      pc1_r   <= pc1_r;
    end
  end

  // Immediate byte capture for LDM/LDD/STD.
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_r <= 8'h00;
    end else if (imm_load_s) begin
      imm_r <= instr_data;
    end else begin
      imm_r <= imm_r;
    end
  end

  // Interrupt request latch; a new INTR wins over a same-cycle acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_req_r    <= 1'b0;
      int_ret_pc_r <= {PC_W{1'b0}};
    end else begin
      if (INTR) begin
        int_req_r <= 1'b1;
      end else if (int_accept_s) begin
        int_req_r <= 1'b0;
      end else begin
        int_req_r <= int_req_r;
      end
      if (int_accept_s) begin
        int_ret_pc_r <= pc_r;
      end else begin
        int_ret_pc_r <= int_ret_pc_r;
      end
    end
  end

  assign instr_addr  = pc_r;
  assign opcode      = instr_r[7:4];
  assign ra          = instr_r[3:2];
  assign rb          = instr_r[1:0];
  assign if_id_valid = valid_r;
  assign if_id_pc1   = pc1_r;
  assign if_id_imm   = imm_r;
  assign int_req     = int_req_r;
  assign int_ret_pc  = int_ret_pc_r;

endmodule
